// File: rtl/fir_share_arb_pkg.sv
// rtl/fir_share_arb_pkg.sv - shared constants, FSM states and helpers for the shared FIR arbiter
package fir_share_arb_pkg;
  localparam int Q_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_STREAM = 3'd2,
    ST_PAD    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  function automatic bit legal_taps(input int t);
    return (t == 4) || (t == 8) || (t == 16) || (t == 32);
  endfunction
endpackage

// File: rtl/fir8.sv
// rtl/fir8.sv - TAPS-point moving average; emits the window ending at the previous sample on each accept
module fir8
  import fir_share_arb_pkg::*;
#(
  parameter int TAPS     = 8,
  parameter int PIPELINE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [Q_W-1:0] sample_in,
  input  logic           valid_in,
  output logic           ready_in,
  output logic [Q_W-1:0] sample_out,
  output logic           valid_out
);
  localparam int LG = $clog2(TAPS);
  localparam int SW = Q_W + LG;

  logic signed [Q_W-1:0] r_tap [TAPS];
  logic [LG:0]           r_fill;
  logic signed [SW-1:0]  w_sum;
  logic [Q_W-1:0]        w_avg;
  logic                  w_emit;

  assign ready_in = 1'b1;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < TAPS; i++) w_sum = w_sum + SW'(r_tap[i]);
  end

  assign w_avg  = Q_W'(w_sum >>> LG);
  assign w_emit = valid_in && (r_fill == (LG+1)'(TAPS));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_tap[i] <= '0;
      r_fill <= '0;
    end else if (valid_in) begin
      r_tap[0] <= sample_in;
      for (int i = 1; i < TAPS; i++) r_tap[i] <= r_tap[i-1];
      if (r_fill != (LG+1)'(TAPS)) r_fill <= r_fill + 1'b1;
    end
  end

  if (PIPELINE == 0) begin : g_comb
    assign sample_out = w_avg;
    assign valid_out  = w_emit;
  end else begin : g_reg
    logic [Q_W-1:0] r_out;
    logic           r_valid;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_out   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_emit;
        if (w_emit) r_out <= w_avg;
      end
    end
    assign sample_out = r_out;
    assign valid_out  = r_valid;
  end
endmodule

// File: rtl/fir_share_arb_rr_arbiter.sv
// rtl/fir_share_arb_rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module fir_share_arb_rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] idx
);
  localparam int IW = $clog2(NCH);

  logic [IW-1:0] w_c;
  logic          w_found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_c     = '0;
    for (int k = 0; k < NCH; k++) begin
      w_c = IW'((int'(ptr) + k) % NCH);
      if (!w_found && req[w_c]) begin
        w_found    = 1'b1;
        grant[w_c] = 1'b1;
        idx        = w_c;
      end
    end
  end
endmodule

// File: rtl/fir_share_arb.sv
// rtl/fir_share_arb.sv - time-shares one fir8 among NCH requesters, one flushed block per grant
module fir_share_arb
  import fir_share_arb_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int TAPS      = 8,
  parameter int PIPELINE  = 0,
  parameter int BLOCK_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*Q_W-1:0]     in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  output logic [NCH-1:0]         grant,
  output logic                   busy,
  output logic                   fir_rst,
  output logic [Q_W-1:0]         fir_sample,
  output logic                   fir_valid,
  input  logic                   fir_ready,
  input  logic [Q_W-1:0]         fir_out,
  input  logic                   fir_out_valid,
  output logic [Q_W-1:0]         out_data,
  output logic                   out_valid,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic                   out_last
);
  localparam int IW  = $clog2(NCH);
  localparam int CW  = $clog2(BLOCK_LEN + 1);
  localparam int EXP = BLOCK_LEN - TAPS + 1;

  if (NCH < 2 || NCH > 8) begin : g_bad_nch
    $error("fir_share_arb: NCH must be 2..8");
  end
  if (!legal_taps(TAPS)) begin : g_bad_taps
    $error("fir_share_arb: TAPS must be 4, 8, 16 or 32");
  end
  if (PIPELINE != 0 && PIPELINE != 1) begin : g_bad_pipe
    $error("fir_share_arb: PIPELINE must be 0 or 1");
  end
  if (BLOCK_LEN < TAPS || BLOCK_LEN > 1024) begin : g_bad_len
    $error("fir_share_arb: BLOCK_LEN must be TAPS..1024");
  end

  state_t         r_state, w_state_nxt;
  logic [NCH-1:0] r_grant;
  logic [IW-1:0]  r_gidx, r_ptr;
  logic [CW-1:0]  r_in_cnt, r_out_cnt;
  logic [Q_W-1:0] r_out_data;
  logic [IW-1:0]  r_out_ch;
  logic           r_out_valid, r_out_last;

  logic [NCH-1:0] w_arb_grant;
  logic [IW-1:0]  w_arb_idx;
  logic [Q_W-1:0] w_sel;
  logic           w_accept, w_res, w_done;

  fir_share_arb_rr_arbiter #(.NCH(NCH)) u_rr (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_arb_grant),
    .idx   (w_arb_idx)
  );

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_gidx == IW'(c)) w_sel = in_data[c*Q_W +: Q_W];
    end
  end

  assign w_accept = (r_state == ST_STREAM) && in_valid[r_gidx] && fir_ready;
  assign w_done   = (r_out_cnt == CW'(EXP));
  // Results only count while a block owns the filter; FLUSH swallows the pad's leftover window.
  assign w_res    = fir_out_valid &&
                    ((r_state == ST_STREAM) || (r_state == ST_PAD) || (r_state == ST_DRAIN));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = '0;
    fir_valid   = 1'b0;
    fir_sample  = '0;
    case (r_state)
      ST_IDLE:   if (|req) w_state_nxt = ST_FLUSH;
      ST_FLUSH:  w_state_nxt = ST_STREAM;
      ST_STREAM: begin
        in_ready[r_gidx] = fir_ready;
        fir_valid        = w_accept;
        fir_sample       = w_sel;
        if (w_accept && r_in_cnt == CW'(BLOCK_LEN - 1)) w_state_nxt = ST_PAD;
      end
      ST_PAD: begin
        fir_valid   = 1'b1;
        w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN:  if (w_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= '0;
      r_gidx      <= '0;
      r_ptr       <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_res;
      r_out_last  <= w_res && (r_out_cnt == CW'(EXP - 1));
      if (w_res) begin
        r_out_data <= fir_out;
        r_out_ch   <= r_gidx;
        r_out_cnt  <= r_out_cnt + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_grant <= w_arb_grant;
            r_gidx  <= w_arb_idx;
          end
        end
        ST_FLUSH: begin
          r_in_cnt  <= '0;
          r_out_cnt <= '0;
        end
        ST_STREAM: if (w_accept) r_in_cnt <= r_in_cnt + 1'b1;
        ST_DRAIN: begin
          if (w_done) begin
            r_ptr   <= (r_gidx == IW'(NCH - 1)) ? '0 : r_gidx + 1'b1;
            r_grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);
  assign fir_rst  = rst || (r_state == ST_FLUSH);
  assign out_data = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch   = r_out_ch;
  assign out_last = r_out_last;
endmodule

// File: tb/tb_fir_share_arb.sv
// tb/tb_fir_share_arb.sv - bench for fir_share_arb with fir8, PIPELINE 0 and 1 instances
module tb_fir_share_arb;
  localparam int NCH  = 4;
  localparam int TAPS = 4;
  localparam int BL   = 8;
  localparam int EXP  = BL - TAPS + 1;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  ch;
    logic        last;
  } res_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic [3:0]  req        [2];
  logic [63:0] in_data    [2];
  logic [3:0]  in_valid   [2];
  logic [3:0]  in_ready   [2];
  logic [3:0]  grant      [2];
  logic        busy       [2];
  logic        fir_rst    [2];
  logic [15:0] fir_sample [2];
  logic        fir_valid  [2];
  logic        fir_ready  [2];
  logic [15:0] fir_out    [2];
  logic        fir_out_valid [2];
  logic [15:0] out_data   [2];
  logic        out_valid  [2];
  logic [1:0]  out_ch     [2];
  logic        out_last   [2];

  int n_tests = 0;
  int n_fail  = 0;
  int mptr [2];
  int bad_nogrant;
  res_t q0[$];
  res_t q1[$];

  fir_share_arb #(.NCH(NCH), .TAPS(TAPS), .PIPELINE(0), .BLOCK_LEN(BL)) u_arb0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .grant(grant[0]), .busy(busy[0]), .fir_rst(fir_rst[0]),
    .fir_sample(fir_sample[0]), .fir_valid(fir_valid[0]), .fir_ready(fir_ready[0]),
    .fir_out(fir_out[0]), .fir_out_valid(fir_out_valid[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_ch(out_ch[0]), .out_last(out_last[0]));

  fir8 #(.TAPS(TAPS), .PIPELINE(0)) u_fir0 (
    .clk(clk), .rst(fir_rst[0]), .sample_in(fir_sample[0]), .valid_in(fir_valid[0]),
    .ready_in(fir_ready[0]), .sample_out(fir_out[0]), .valid_out(fir_out_valid[0]));

  fir_share_arb #(.NCH(NCH), .TAPS(TAPS), .PIPELINE(1), .BLOCK_LEN(BL)) u_arb1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .grant(grant[1]), .busy(busy[1]), .fir_rst(fir_rst[1]),
    .fir_sample(fir_sample[1]), .fir_valid(fir_valid[1]), .fir_ready(fir_ready[1]),
    .fir_out(fir_out[1]), .fir_out_valid(fir_out_valid[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_ch(out_ch[1]), .out_last(out_last[1]));

  fir8 #(.TAPS(TAPS), .PIPELINE(1)) u_fir1 (
    .clk(clk), .rst(fir_rst[1]), .sample_in(fir_sample[1]), .valid_in(fir_valid[1]),
    .ready_in(fir_ready[1]), .sample_out(fir_out[1]), .valid_out(fir_out_valid[1]));

  always @(negedge clk) begin
    res_t r;
    if (out_valid[0]) begin
      r.d = out_data[0]; r.ch = out_ch[0]; r.last = out_last[0];
      q0.push_back(r);
    end
    if (out_valid[1]) begin
      r.d = out_data[1]; r.ch = out_ch[1]; r.last = out_last[1];
      q1.push_back(r);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input int u, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL p%0d %s: observed %0h expected %0h", u, tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpop(input int u, output res_t r);
    if (u == 0) r = q0.pop_front();
    else        r = q1.pop_front();
  endtask

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < NCH; k++) begin
      if (r[(p + k) % NCH]) return (p + k) % NCH;
    end
    return -1;
  endfunction

  // Average of the TAPS samples that end just before sample index w, rounded toward -inf.
  function automatic logic [15:0] exp_avg(input int s[8], input int w);
    int sum = 0;
    int q;
    for (int k = w - TAPS; k < w; k++) sum += s[k];
    q = sum / TAPS;
    if ((sum % TAPS != 0) && (sum < 0)) q--;
    return 16'(q);
  endfunction

  task automatic do_reset(input int u);
    rst[u] = 1'b1; req[u] = '0; in_valid[u] = '0; in_data[u] = '0;
    tick(); tick();
    check(u, "rst_grant", grant[u], 0);
    check(u, "rst_in_ready", in_ready[u], 0);
    check(u, "rst_busy", busy[u], 0);
    check(u, "rst_out_valid", out_valid[u], 0);
    check(u, "rst_out_last", out_last[u], 0);
    check(u, "rst_out_data", out_data[u], 0);
    check(u, "rst_out_ch", out_ch[u], 0);
    check(u, "rst_fir_rst", fir_rst[u], 1);
    check(u, "rst_fir_valid", fir_valid[u], 0);
    rst[u] = 1'b0;
    tick();
    mptr[u] = 0;
    if (u == 0) q0.delete(); else q1.delete();
  endtask

  task automatic wait_grant(input int u, input logic [3:0] oh);
    int cyc = 0;
    while (grant[u] !== oh && cyc < 20) begin tick(); cyc++; end
    check(u, "grant", grant[u], oh);
  endtask

  task automatic feed(input int u, input int ch, input int s[8], input int n, input int mode);
    int idx = 0;
    int cyc = 0;
    bit v;
    bit ph = 1'b1;
    logic [63:0] d;
    while (idx < n && cyc < 200) begin
      d = {$urandom, $urandom};
      d[16*ch +: 16] = 16'(s[idx]);
      in_data[u] = d;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ph : ($urandom_range(0, 2) != 0);
      ph = ~ph;
      in_valid[u] = 4'($urandom);
      in_valid[u][ch] = v;
      if ((in_ready[u] & ~(4'b0001 << ch)) != 4'b0) bad_nogrant++;
      if (v && in_ready[u][ch]) idx++;
      tick();
      cyc++;
    end
    in_valid[u] = '0;
    check(u, "accepts", idx, n);
  endtask

  task automatic run_block(input int u, input logic [3:0] reqv, input bit hold, input int mode,
                           input int s[8]);
    int ch;
    int cyc = 0;
    int got;
    res_t r;
    ch = pick(mptr[u], reqv);
    bad_nogrant = 0;
    req[u] = reqv;
    wait_grant(u, 4'(1 << ch));
    if (!hold) req[u] = '0;
    feed(u, ch, s, BL, mode);
    while (!(qsize(u) >= EXP && grant[u] == 4'b0) && cyc < 100) begin tick(); cyc++; end
    got = qsize(u);
    check(u, "n_results", got, EXP);
    check(u, "busy_end", busy[u], 0);
    check(u, "nongrant_ready", bad_nogrant, 0);
    for (int i = 0; i < EXP && i < got; i++) begin
      qpop(u, r);
      check(u, $sformatf("data ch%0d #%0d", ch, i), r.d, exp_avg(s, TAPS + i));
      check(u, $sformatf("ch #%0d", i), r.ch, ch);
      check(u, $sformatf("last #%0d", i), r.last, (i == EXP - 1));
    end
    if (u == 0) q0.delete(); else q1.delete();
    mptr[u] = (ch + 1) % NCH;
  endtask

  initial begin
    int s[8];
    int nlast;
    int cyc;
    logic [3:0] reqv;
    res_t r;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req[u] = '0; in_valid[u] = '0; in_data[u] = '0;
    end

    for (int u = 0; u < 2; u++) begin
      do_reset(u);

      for (int i = 0; i < BL; i++) s[i] = 1000;
      run_block(u, 4'b0001, 1'b0, 0, s);

      for (int i = 0; i < BL; i++) s[i] = 4 * i;
      run_block(u, 4'b0100, 1'b0, 0, s);

      do_reset(u);
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < BL; i++) s[i] = int'($urandom_range(0, 65535)) - 32768;
        run_block(u, 4'b1011, 1'b1, 2, s);
      end
      req[u] = '0;

      for (int i = 0; i < BL; i++) s[i] = 30000;
      run_block(u, 4'b0001, 1'b0, 0, s);
      for (int i = 0; i < BL; i++) s[i] = -1000;
      run_block(u, 4'b0010, 1'b0, 0, s);

      for (int i = 0; i < BL; i++) s[i] = int'($urandom_range(0, 65535)) - 32768;
      run_block(u, 4'b1000, 1'b0, 1, s);

      for (int b = 0; b < 3; b++) begin
        reqv = 4'($urandom_range(1, 15));
        for (int i = 0; i < BL; i++) s[i] = int'($urandom_range(0, 65535)) - 32768;
        run_block(u, reqv, 1'b0, 2, s);
      end

      do_reset(u);
      for (int i = 0; i < BL; i++) s[i] = int'($urandom_range(0, 65535)) - 32768;
      req[u] = 4'b0010;
      wait_grant(u, 4'b0010);
      req[u] = '0;
      feed(u, 1, s, 5, 0);
      rst[u] = 1'b1;
      tick();
      check(u, "abort_grant", grant[u], 0);
      check(u, "abort_out_valid", out_valid[u], 0);
      check(u, "abort_out_last", out_last[u], 0);
      check(u, "abort_busy", busy[u], 0);
      check(u, "abort_in_ready", in_ready[u], 0);
      tick();
      rst[u] = 1'b0;
      tick();
      nlast = 0;
      while (qsize(u) > 0) begin
        qpop(u, r);
        if (r.last) nlast++;
      end
      check(u, "abort_no_last", nlast, 0);
      mptr[u] = 0;
      for (int i = 0; i < BL; i++) s[i] = int'($urandom_range(0, 65535)) - 32768;
      run_block(u, 4'b0011, 1'b0, 0, s);

      cyc = 0;
      while (cyc < 10) begin tick(); cyc++; end
      check(u, "no_stray_results", qsize(u), 0);
      check(u, "idle_busy", busy[u], 0);
      rst[u] = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
